// File: rtl/mips_debug_master.sv
// mips_debug_master: command-driven controller for the MIPS debug port (run/halt/step/read/dump)
module mips_debug_master #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 32,
  parameter int STEP_CYCLES = 1,
  parameter int READ_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic              cmd_err,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_last,
  output logic              halted,
  output logic              debug_en,
  output logic              debug_step,
  output logic [ADDR_W-1:0] debug_addr,
  input  logic [DATA_W-1:0] debug_data
);
  typedef enum logic [1:0] {IDLE, STEP, SETTLE, RESP} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] end_addr;
  logic [3:0] cnt;
  logic acc, rsp_hs, cnt_z;
  assign acc = cmd_valid && cmd_ready;
  assign rsp_hs = rsp_valid && rsp_ready;
  assign cnt_z = cnt == 4'd0;
  assign halted = debug_en;
  // next-state: STEP only when halted, READ/DUMP settle, RESP loops until the last word
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (acc) state_n = (cmd_op == 3'd2 && debug_en) ? STEP :
                                  (cmd_op == 3'd3 || cmd_op == 3'd4) ? SETTLE : IDLE;
      STEP:    state_n = cnt_z ? IDLE : STEP;
      SETTLE:  state_n = cnt_z ? RESP : SETTLE;
      RESP:    if (rsp_hs) state_n = rsp_last ? IDLE : SETTLE;
      default: state_n = IDLE;
    endcase
  end
  // state register and datapath; cmd_ready is registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      cmd_err    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_addr   <= '0;
      rsp_last   <= 1'b0;
      debug_en   <= 1'b0;
      debug_step <= 1'b0;
      debug_addr <= '0;
      end_addr   <= '0;
      cnt        <= '0;
    end else begin
      state     <= state_n;
      cmd_ready <= state_n == IDLE;
      cmd_err   <= 1'b0;
      case (state)
        IDLE: if (acc) begin
          case (cmd_op)
            3'd0: debug_en <= 1'b0;
            3'd1: debug_en <= 1'b1;
            3'd2: if (debug_en) begin
              debug_step <= 1'b1;
              cnt        <= 4'(STEP_CYCLES - 1);
            end else cmd_err <= 1'b1;
            3'd3: begin
              debug_addr <= cmd_addr;
              end_addr   <= cmd_addr;
              cnt        <= 4'(READ_LAT);
            end
            3'd4: begin
              debug_addr <= '0;
              end_addr   <= cmd_addr;
              cnt        <= 4'(READ_LAT);
            end
            default: cmd_err <= 1'b1;
          endcase
        end
        STEP: if (cnt_z) debug_step <= 1'b0; else cnt <= cnt - 4'd1;
        SETTLE: if (cnt_z) begin
          rsp_data  <= debug_data;
          rsp_addr  <= debug_addr;
          rsp_last  <= debug_addr == end_addr;
          rsp_valid <= 1'b1;
        end else cnt <= cnt - 4'd1;
        RESP: if (rsp_hs) begin
          rsp_valid <= 1'b0;
          if (!rsp_last) begin
            debug_addr <= debug_addr + ADDR_W'(1);
            cnt        <= 4'(READ_LAT);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_debug_master.sv
// tb_mips_debug_master: directed self-checking bench for the debug master
module tb_mips_debug_master;
  logic clk = 0, rst = 1, mode = 0;
  int checks = 0, errors = 0;
  logic cmd_valid = 0, cmd_ready, cmd_err, rsp_valid, rsp_ready = 0, rsp_last, halted, debug_en, debug_step;
  logic [2:0] cmd_op = 0;
  logic [6:0] cmd_addr = 0, rsp_addr, debug_addr;
  logic [31:0] rsp_data, debug_data;
  logic cmd_valid_b = 0, cmd_ready_b, cmd_err_b, rsp_valid_b, rsp_ready_b = 1, rsp_last_b, halted_b, debug_en_b, debug_step_b;
  logic [2:0] cmd_op_b = 0;
  logic [6:0] cmd_addr_b = 0, rsp_addr_b, debug_addr_b;
  logic [31:0] rsp_data_b, debug_data_b;
  always #5 clk = ~clk;
  assign debug_data = mode ? {23'd0, debug_addr, 2'b00} : (32'hDEAD_0000 | 32'(debug_addr));
  assign debug_data_b = 32'hDEAD_0000 | 32'(debug_addr_b);
  mips_debug_master dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_err(cmd_err), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_addr(rsp_addr), .rsp_last(rsp_last), .halted(halted),
    .debug_en(debug_en), .debug_step(debug_step), .debug_addr(debug_addr), .debug_data(debug_data));
  mips_debug_master #(.STEP_CYCLES(3), .READ_LAT(4)) dut_b (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_op(cmd_op_b),
    .cmd_addr(cmd_addr_b), .cmd_err(cmd_err_b), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
    .rsp_data(rsp_data_b), .rsp_addr(rsp_addr_b), .rsp_last(rsp_last_b), .halted(halted_b),
    .debug_en(debug_en_b), .debug_step(debug_step_b), .debug_addr(debug_addr_b), .debug_data(debug_data_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [6:0] addr);
    cmd_valid = 1; cmd_op = op; cmd_addr = addr;
    tick();
    cmd_valid = 0;
  endtask

  task automatic send_b(input logic [2:0] op, input logic [6:0] addr);
    cmd_valid_b = 1; cmd_op_b = op; cmd_addr_b = addr;
    tick();
    cmd_valid_b = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    tick(); tick();
    rst = 0;
    checks++;
    if ({cmd_ready, debug_en, debug_step, rsp_valid, cmd_err, debug_addr} !== {5'b10000, 7'd0}) begin
      errors++;
      $display("FAIL reset_state got %b exp 100000000000", {cmd_ready, debug_en, debug_step, rsp_valid, cmd_err, debug_addr});
    end
    tick();
    checks++;
    if ({cmd_ready, halted, rsp_last, rsp_data} !== {3'b100, 32'd0}) begin
      errors++;
      $display("FAIL reset_idle got rdy=%b halted=%b last=%b data=%h", cmd_ready, halted, rsp_last, rsp_data);
    end
  endtask

  task automatic test_step();
    send(3'd1, 0);
    checks++;
    if ({debug_en, halted, cmd_ready} !== 3'b111) begin
      errors++;
      $display("FAIL halt got en/halted/rdy=%b exp 111", {debug_en, halted, cmd_ready});
    end
    send(3'd2, 0);
    checks++;
    if ({debug_step, cmd_ready} !== 2'b10) begin
      errors++;
      $display("FAIL step_high got step/rdy=%b exp 10", {debug_step, cmd_ready});
    end
    tick();
    checks++;
    if ({debug_step, cmd_ready, debug_en} !== 3'b011) begin
      errors++;
      $display("FAIL step_end got step/rdy/en=%b exp 011", {debug_step, cmd_ready, debug_en});
    end
    send(3'd0, 0);
    send(3'd2, 0);
    checks++;
    if ({cmd_err, debug_step, debug_en, cmd_ready} !== 4'b1001) begin
      errors++;
      $display("FAIL step_running got err/step/en/rdy=%b exp 1001", {cmd_err, debug_step, debug_en, cmd_ready});
    end
    tick();
    checks++;
    if ({cmd_err, debug_step} !== 2'b00) begin
      errors++;
      $display("FAIL err_pulse got err/step=%b exp 00", {cmd_err, debug_step});
    end
  endtask

  task automatic test_read();
    mode = 0; rsp_ready = 1;
    send(3'd3, 7'd7);
    checks++;
    if ({debug_addr, cmd_ready, rsp_valid} !== {7'd7, 2'b00}) begin
      errors++;
      $display("FAIL read_accept got addr=%0d rdy=%b vld=%b exp 7 0 0", debug_addr, cmd_ready, rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_early got vld=%b exp 0", rsp_valid);
    end
    tick();
    checks++;
    if ({rsp_valid, rsp_data, rsp_addr, rsp_last} !== {1'b1, 32'hDEAD_0007, 7'd7, 1'b1}) begin
      errors++;
      $display("FAIL read_rsp got vld=%b data=%h addr=%0d last=%b exp 1 dead0007 7 1", rsp_valid, rsp_data, rsp_addr, rsp_last);
    end
    tick();
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      errors++;
      $display("FAIL read_done got vld/rdy=%b exp 01", {rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_dump();
    int e = 0;
    logic pv = 0, pr = 0;
    logic [31:0] pd = 0;
    logic [6:0] pa = 0;
    mode = 1; rsp_ready = 0;
    send(3'd4, 7'd3);
    for (int c = 0; c < 80 && e < 4; c++) begin
      rsp_ready = (c % 2) == 1;
      if (pv && !pr) begin
        checks++;
        if ({rsp_valid, rsp_data, rsp_addr} !== {1'b1, pd, pa}) begin
          errors++;
          $display("FAIL dump_stall got vld=%b data=%h addr=%0d exp 1 %h %0d", rsp_valid, rsp_data, rsp_addr, pd, pa);
        end
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if ({rsp_addr, rsp_data, rsp_last} !== {7'(e), 32'(e * 4), 1'(e == 3)}) begin
          errors++;
          $display("FAIL dump_word%0d got addr=%0d data=%h last=%b exp %0d %h %b", e, rsp_addr, rsp_data, rsp_last, e, e * 4, e == 3);
        end
        e++;
      end
      pv = rsp_valid; pr = rsp_ready; pd = rsp_data; pa = rsp_addr;
      tick();
    end
    rsp_ready = 0;
    checks++;
    if (e != 4) begin
      errors++;
      $display("FAIL dump_count got %0d exp 4", e);
    end
    checks++;
    if ({cmd_ready, rsp_valid, debug_addr} !== {2'b10, 7'd3}) begin
      errors++;
      $display("FAIL dump_done got rdy/vld=%b addr=%0d exp 10 3", {cmd_ready, rsp_valid}, debug_addr);
    end
  endtask

  task automatic test_illegal();
    send(3'd6, 7'd9);
    checks++;
    if ({cmd_err, cmd_ready, debug_en, debug_step, rsp_valid, debug_addr} !== {5'b11000, 7'd3}) begin
      errors++;
      $display("FAIL illegal got err/rdy/en/step/vld=%b addr=%0d exp 11000 3", {cmd_err, cmd_ready, debug_en, debug_step, rsp_valid}, debug_addr);
    end
    tick();
    checks++;
    if ({cmd_err, cmd_ready} !== 2'b01) begin
      errors++;
      $display("FAIL illegal_end got err/rdy=%b exp 01", {cmd_err, cmd_ready});
    end
  endtask

  task automatic test_reset_mid_dump();
    logic found = 0;
    mode = 1; rsp_ready = 0;
    send(3'd1, 0);
    send(3'd4, 7'd5);
    for (int c = 0; c < 60 && !found; c++) begin
      if (rsp_valid && rsp_addr == 7'd2) found = 1;
      else begin
        rsp_ready = rsp_valid;
        tick();
      end
    end
    rsp_ready = 0;
    checks++;
    if ({found, rsp_valid, rsp_addr, debug_addr} !== {2'b11, 7'd2, 7'd2}) begin
      errors++;
      $display("FAIL mid_dump_reach got found=%b vld=%b addr=%0d/%0d exp 1 1 2/2", found, rsp_valid, rsp_addr, debug_addr);
    end
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if ({cmd_ready, rsp_valid, debug_en, debug_addr} !== {3'b100, 7'd0}) begin
      errors++;
      $display("FAIL mid_dump_reset got rdy/vld/en=%b addr=%0d exp 100 0", {cmd_ready, rsp_valid, debug_en}, debug_addr);
    end
  endtask

  task automatic test_timing();
    send_b(3'd1, 0);
    send_b(3'd2, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({debug_step_b, cmd_ready_b} !== 2'b10) begin
        errors++;
        $display("FAIL long_step%0d got step/rdy=%b exp 10", i, {debug_step_b, cmd_ready_b});
      end
      tick();
    end
    checks++;
    if ({debug_step_b, cmd_ready_b} !== 2'b01) begin
      errors++;
      $display("FAIL long_step_end got step/rdy=%b exp 01", {debug_step_b, cmd_ready_b});
    end
    send_b(3'd3, 7'd5);
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (rsp_valid_b !== 1'b0) begin
        errors++;
        $display("FAIL lat_early%0d got vld=%b exp 0", i, rsp_valid_b);
      end
    end
    tick();
    checks++;
    if ({rsp_valid_b, rsp_data_b, rsp_addr_b, rsp_last_b} !== {1'b1, 32'hDEAD_0005, 7'd5, 1'b1}) begin
      errors++;
      $display("FAIL lat_rsp got vld=%b data=%h addr=%0d last=%b exp 1 dead0005 5 1", rsp_valid_b, rsp_data_b, rsp_addr_b, rsp_last_b);
    end
    tick();
    send_b(3'd2, 0);
    tick();
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if ({debug_step_b, debug_en_b, cmd_ready_b} !== 3'b001) begin
      errors++;
      $display("FAIL mid_step_reset got step/en/rdy=%b exp 001", {debug_step_b, debug_en_b, cmd_ready_b});
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_read();
    test_dump();
    test_illegal();
    test_reset_mid_dump();
    test_timing();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_debug_master.md
Name: mips_debug_master

Overview:
- Host-side driver of the MIPS core's debug port. It owns debug_en, debug_step and debug_addr, and it samples debug_data.
- It accepts simple commands (run, halt, single-step, read one debug register, dump a register range) over a valid/ready command channel.
- It returns captured debug words over a valid/ready response channel.
- It sits between the board-level debug front end (UART/VGA/switch logic) and the mips top level.

Parameters:
- ADDR_W, 7, debug address width; must match the mips debug_addr width.
- DATA_W, 32, debug data width.
- STEP_CYCLES, 1, number of cycles debug_step is held high per STEP command (range 1..15).
- READ_LAT, 1, cycles between driving debug_addr and sampling debug_data (range 1..15).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_op  input  3  000 RUN, 001 HALT, 010 STEP, 011 READ, 100 DUMP; 101–111 are illegal.
- cmd_addr  input  ADDR_W  register address for READ; last address for DUMP.
- cmd_err  output  1  one-cycle pulse when a command is rejected.
- rsp_valid  output  1  response word available.
- rsp_ready  input  1  consumer accepts the response.
- rsp_data  output  DATA_W  captured debug_data.
- rsp_addr  output  ADDR_W  address the word was read from.
- rsp_last  output  1  marks the final word of a READ or DUMP.
- halted  output  1  mirrors debug_en.
- debug_en  output  1  to mips; 1 = core halted under debug control.
- debug_step  output  1  to mips; step pulse.
- debug_addr  output  ADDR_W  to mips.
- debug_data  input  DATA_W  from mips.

Behaviour:
- Reset (rst=1 at an edge) forces:
  - all outputs to 0 except cmd_ready=1;
  - FSM to IDLE;
  - counters cleared.
- Reset mid-STEP or mid-DUMP aborts immediately: debug_step=0 and rsp_valid=0 after that edge.
- FSM states are IDLE, STEP, SETTLE, RESP. cmd_ready=1 only in IDLE (registered).
- Handshake: a command is accepted on an edge with cmd_valid && cmd_ready.
- IDLE, on accept:
  - RUN: debug_en<=0 and stay in IDLE.
  - HALT: debug_en<=1 and stay in IDLE. Repeated RUN/HALT is idempotent.
  - STEP while debug_en=0: cmd_err=1 for one cycle, no other effect.
  - STEP while debug_en=1: debug_step<=1, load step counter, go to STEP.
  - READ: debug_addr<=cmd_addr, end_addr<=cmd_addr, load latency counter, go to SETTLE. READ is legal in either run state.
  - DUMP: debug_addr<=0, end_addr<=cmd_addr, go to SETTLE.
  - Illegal op: cmd_err pulse, stay in IDLE.
- STEP state:
  - debug_step stays high for exactly STEP_CYCLES cycles.
  - Then debug_step<=0 and the FSM returns to IDLE.
  - cmd_ready is asserted again on the same edge that clears debug_step.
- SETTLE state:
  - Wait READ_LAT cycles counted from the cycle debug_addr becomes valid.
  - On the final edge capture:
    - rsp_data<=debug_data;
    - rsp_addr<=debug_addr;
    - rsp_last<=(debug_addr==end_addr);
    - rsp_valid<=1;
    - go to RESP.
- RESP state:
  - rsp_valid, rsp_data, rsp_addr and rsp_last stay stable until rsp_ready=1 at an edge.
  - On handshake, rsp_valid<=0.
  - If rsp_last, return to IDLE.
  - Otherwise debug_addr<=debug_addr+1, reload the latency counter, go to SETTLE.
- READ latency: accept at edge N, so debug_addr is valid after N. With READ_LAT=1, capture occurs at N+2 and rsp_valid is high from N+2.
- DUMP produces end_addr+1 responses.
  - cmd_addr=0 gives a single word with rsp_last=1.
  - cmd_addr=127 reads 0..127; address arithmetic never wraps because the loop ends at end_addr.
- Back-pressure: rsp_ready held low stalls indefinitely with no loss. debug_addr is held while stalled.
- debug_en is unchanged by READ/DUMP/STEP. HALT/RUN are only acceptable in IDLE.

Test Plan:
- Reset then idle: after rst pulse, cmd_ready=1, debug_en=0, debug_step=0, rsp_valid=0, debug_addr=0.
- HALT then STEP with STEP_CYCLES=1 → debug_en=1; debug_step high for exactly 1 cycle; cmd_ready low during it. STEP issued after RUN → cmd_err one-cycle pulse and debug_step stays 0.
- READ cmd_addr=7 with model debug_data=32'hDEAD_0007 at addr 7, rsp_ready=1 → rsp_valid asserted 2 cycles after accept with rsp_data=32'hDEAD_0007, rsp_addr=7, rsp_last=1; back to IDLE.
- DUMP cmd_addr=3 with model data = addr*4, rsp_ready toggled 1/0 → responses 0,4,8,12 in order on addrs 0..3, no duplicates or drops; rsp_last only on addr 3; data stable while rsp_ready=0.
- Illegal op 3'b110 → cmd_err pulse, no output change. Reset asserted while in RESP of a DUMP at addr 2 → next cycle rsp_valid=0, FSM IDLE, debug_addr=0.
- Timing with STEP_CYCLES=3, READ_LAT=4 → debug_step high exactly 3 cycles; READ capture at accept+5.
